// File: rtl/vector_acc_axil_slave.sv
// AXI4-Lite slave: four scratch registers plus a scalar
// accumulate engine that raises DONE/irq after LEN elements.
module vector_acc_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  logic [31:0] scratch [4];
  logic [31:0] acc;
  logic [15:0] len;
  logic [15:0] count;
  logic        irq_en;
  logic        done;
  logic [31:0] rd_mux;
  logic [2:0]  wr_idx;
  logic [2:0]  rd_idx;
  logic        wr_en;
  logic        rd_en;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];
  assign wr_en  = S_AXI_AWREADY && S_AXI_AWVALID &&
                  S_AXI_WREADY && S_AXI_WVALID;
  assign rd_en  = S_AXI_ARREADY && S_AXI_ARVALID;

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  always_comb begin
    rd_mux = 32'h0;
    case (rd_idx)
      3'd0, 3'd1,
      3'd2, 3'd3: rd_mux = scratch[rd_idx[1:0]];
      3'd4:       rd_mux = {len, 14'h0, irq_en, 1'b0};
      3'd6:       rd_mux = acc;
      3'd7:       rd_mux = {count, 15'h0, done};
      default:    rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= 32'h0;
    end else begin
      S_AXI_AWREADY <= !S_AXI_AWREADY && S_AXI_AWVALID &&
                       S_AXI_WVALID && !S_AXI_BVALID;
      S_AXI_WREADY  <= !S_AXI_AWREADY && S_AXI_AWVALID &&
                       S_AXI_WVALID && !S_AXI_BVALID;
      if (wr_en)
        S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY)
        S_AXI_BVALID <= 1'b0;
      S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID &&
                       !S_AXI_RVALID;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++)
        scratch[i] <= 32'h0;
      acc    <= 32'h0;
      len    <= 16'h0;
      count  <= 16'h0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      done <= (len != 16'h0) && (count >= len);
      irq  <= done && irq_en;
      // CLEAR is placed after the DONE update so it wins
      if (wr_en) begin
        if (!wr_idx[2]) begin
          for (int b = 0; b < 4; b++)
            if (S_AXI_WSTRB[b])
              scratch[wr_idx[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end else if (wr_idx == 3'd4) begin
          if (S_AXI_WSTRB[0]) begin
            irq_en <= S_AXI_WDATA[1];
            if (S_AXI_WDATA[0]) begin
              acc   <= 32'h0;
              count <= 16'h0;
              done  <= 1'b0;
            end
          end
          if (S_AXI_WSTRB[2])
            len[7:0] <= S_AXI_WDATA[23:16];
          if (S_AXI_WSTRB[3])
            len[15:8] <= S_AXI_WDATA[31:24];
        end else if (wr_idx == 3'd5 && S_AXI_WSTRB == 4'hF
                     && !done) begin
          acc   <= acc + S_AXI_WDATA;
          count <= count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_acc_axil_slave.sv
// Bench for vector_acc_axil_slave: vector table plus
// read scoreboard, and a stall/reset corner sequence.
module tb_vector_acc_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        irq;

  always #5 ACLK = ~ACLK;

  vector_acc_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .irq(irq)
  );

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_IRQ = 2;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  vec_t        tbl[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  always @(negedge ACLK) begin
    if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h expected none", S_AXI_RDATA);
      end else begin
        check(name_q.pop_front(), S_AXI_RDATA, exp_q.pop_front());
        check("rresp", 32'(S_AXI_RRESP), 32'h0);
      end
    end
  end

  function automatic vec_t mk(input int k, input logic [4:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] e, input string n);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d;
    v.strb = s; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n = 0;
    @(posedge ACLK); #1;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    while (!S_AXI_AWREADY && n < 20) begin
      @(posedge ACLK); #1; n++;
    end
    if (!S_AXI_AWREADY) timeout("aw_wait");
    check("wready", 32'(S_AXI_WREADY), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("bvalid", 32'(S_AXI_BVALID), 32'h1);
    check("awready_pulse", 32'(S_AXI_AWREADY), 32'h0);
    check("bresp", 32'(S_AXI_BRESP), 32'h0);
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] e,
                          input string name);
    int n = 0;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && n < 20) begin
      @(posedge ACLK); #1; n++;
    end
    if (!S_AXI_ARREADY) timeout("ar_wait");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("arready_pulse", 32'(S_AXI_ARREADY), 32'h0);
  endtask

  initial begin
    int n;
    // test 1 + unaligned access
    tbl.push_back(mk(K_WR, 5'h00, 32'd1, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h04, 32'd2, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h08, 32'd3, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h0C, 32'd4, 4'hF, 0, ""));
    tbl.push_back(mk(K_RD, 5'h00, 0, 0, 32'd1, "t1_s0"));
    tbl.push_back(mk(K_RD, 5'h04, 0, 0, 32'd2, "t1_s1"));
    tbl.push_back(mk(K_RD, 5'h08, 0, 0, 32'd3, "t1_s2"));
    tbl.push_back(mk(K_RD, 5'h0C, 0, 0, 32'd4, "t1_s3"));
    tbl.push_back(mk(K_WR, 5'h07, 32'h5A5A_1234, 4'hF, 0, ""));
    tbl.push_back(mk(K_RD, 5'h05, 0, 0, 32'h5A5A_1234, "unaligned"));
    // test 2
    tbl.push_back(mk(K_WR, 5'h00, 32'hAABB_CCDD, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h00, 32'h1122_3344, 4'h5, 0, ""));
    tbl.push_back(mk(K_RD, 5'h00, 0, 0, 32'hAA22_CC44, "t2_strb"));
    // test 3
    tbl.push_back(mk(K_WR, 5'h10, 32'h0003_0002, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h14, 32'd10, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h14, 32'hFFFF_FFFD, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h14, 32'd5, 4'hF, 0, ""));
    tbl.push_back(mk(K_IRQ, 0, 0, 0, 32'd1, "t3_irq"));
    tbl.push_back(mk(K_RD, 5'h18, 0, 0, 32'd12, "t3_acc"));
    tbl.push_back(mk(K_RD, 5'h1C, 0, 0, 32'h0003_0001, "t3_status"));
    tbl.push_back(mk(K_WR, 5'h14, 32'd100, 4'hF, 0, ""));
    tbl.push_back(mk(K_RD, 5'h18, 0, 0, 32'd12, "t3_acc_held"));
    tbl.push_back(mk(K_RD, 5'h1C, 0, 0, 32'h0003_0001, "t3_cnt_held"));
    tbl.push_back(mk(K_RD, 5'h14, 0, 0, 32'd0, "datain_rd0"));
    // test 5
    tbl.push_back(mk(K_WR, 5'h10, 32'h0003_0003, 4'hF, 0, ""));
    tbl.push_back(mk(K_IRQ, 0, 0, 0, 32'd0, "t5_irq"));
    tbl.push_back(mk(K_RD, 5'h18, 0, 0, 32'd0, "t5_acc"));
    tbl.push_back(mk(K_RD, 5'h1C, 0, 0, 32'd0, "t5_status"));
    tbl.push_back(mk(K_RD, 5'h10, 0, 0, 32'h0003_0002, "t5_ctrl"));
    // test 4, including partial strobe before DONE
    tbl.push_back(mk(K_WR, 5'h10, 32'h0002_0001, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h14, 32'd5, 4'h7, 0, ""));
    tbl.push_back(mk(K_RD, 5'h1C, 0, 0, 32'd0, "t4_partial"));
    tbl.push_back(mk(K_WR, 5'h14, 32'hFFFF_FFFF, 4'hF, 0, ""));
    tbl.push_back(mk(K_WR, 5'h14, 32'd2, 4'hF, 0, ""));
    tbl.push_back(mk(K_RD, 5'h18, 0, 0, 32'd1, "t4_acc_wrap"));
    tbl.push_back(mk(K_RD, 5'h1C, 0, 0, 32'h0002_0001, "t4_status"));
    tbl.push_back(mk(K_IRQ, 0, 0, 0, 32'd0, "t4_irq_off"));
    tbl.push_back(mk(K_WR, 5'h14, 32'd7, 4'h7, 0, ""));
    tbl.push_back(mk(K_RD, 5'h18, 0, 0, 32'd1, "t4_acc_held"));
    tbl.push_back(mk(K_WR, 5'h18, 32'hDEAD_BEEF, 4'hF, 0, ""));
    tbl.push_back(mk(K_RD, 5'h18, 0, 0, 32'd1, "ro_acc"));

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_outs",
          32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RVALID, irq}), 32'h0);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    ARESETN = 1'b1;

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_WR: axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        K_RD: axi_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
        default: begin
          repeat (2) @(posedge ACLK);
          #1;
          check(tbl[i].name, 32'(irq), tbl[i].exp);
        end
      endcase
    end

    // test 6: stalled responses, then reset mid-transaction
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin
      @(posedge ACLK); #1; n++;
    end
    if (!S_AXI_AWREADY) timeout("t6_aw_wait");
    check("t6_arready", 32'(S_AXI_ARREADY), 32'h1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    S_AXI_WDATA = 32'h99;
    for (int i = 0; i < 10; i++) begin
      check("t6_bvalid", 32'(S_AXI_BVALID), 32'h1);
      check("t6_rvalid", 32'(S_AXI_RVALID), 32'h1);
      check("t6_rdata", S_AXI_RDATA, 32'd3);
      check("t6_no_awready", 32'(S_AXI_AWREADY), 32'h0);
      @(posedge ACLK); #1;
    end
    #2 ARESETN = 1'b0;
    #1;
    check("t6_rst_outs",
          32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RVALID, irq}), 32'h0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    for (int i = 0; i < 8; i++)
      axi_read(5'(i * 4), 32'h0, "t6_reg_zero");

    repeat (3) @(posedge ACLK);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/vector_acc_axil_slave.md
Name: vector_acc_axil_slave

Overview:
AXI4-Lite slave register block for the vector accelerator IP. It is the responder end of the master-driven AXI4-Lite write/read sequence used in the IP's bring-up bench. The block provides four RW scratch registers, with byte strobes and readback, and a scalar accumulate engine. Software streams 32-bit elements into DATA_IN, and the block raises DONE and IRQ once LEN elements have been summed.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word registers via addr[4:2].

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous, active-low reset
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
irq  out  1  registered DONE & IRQ_EN

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All READY, VALID, RDATA and irq outputs are 0.
  - All registers, ACC, COUNT and DONE are 0.
  - In-flight transactions are dropped; no response is issued after reset.
- Write channel:
  - While AWVALID & WVALID & !BVALID & !AWREADY, AWREADY and WREADY go high together on the next edge for exactly 1 cycle.
  - The register update and BVALID=1 occur on the edge ending that handshake cycle.
  - BVALID holds until BREADY. No new AW/W is accepted while BVALID=1, so at most one write is outstanding.
- Read channel:
  - While ARVALID & !RVALID & !ARREADY, ARREADY pulses high for 1 cycle on the next edge.
  - RDATA is latched and RVALID=1 on the edge ending that cycle.
  - RDATA is held stable until RREADY.
  - RDATA samples values before any write committing on the same edge.
- Read and write channels are fully independent.
- Register map (addr[4:2]):
  - 0-3 SCRATCH0-3: RW, per-byte WSTRB.
  - 4 CTRL: bit0 CLEAR (write-1 pulse, reads 0); bit1 IRQ_EN; [31:16] LEN; other bits read 0. Honors WSTRB.
  - 5 DATA_IN: WO, reads 0.
    - A write with WSTRB=4'hF and DONE=0 sets ACC <= ACC + WDATA (mod 2^32; two's-complement wrap, no saturation) and COUNT <= COUNT+1.
    - A write with a partial strobe, or with DONE=1, is ignored.
  - 6 ACC: RO.
  - 7 STATUS: RO; bit0 DONE, [31:16] COUNT.
  - Writes to RO registers are ignored. Every access returns OKAY.
- DONE is evaluated every cycle: DONE <= (LEN!=0) && (COUNT>=LEN). With LEN=0 the block never completes. Lowering LEN to or below COUNT sets DONE on the next edge.
- CLEAR zeroes ACC, COUNT and DONE on the commit edge. LEN and IRQ_EN take their newly written values.
- irq is registered, so it lags DONE & IRQ_EN by 1 cycle.
- Unaligned address bits [1:0] are ignored.

Test Plan:
1. Write 1,2,3,4 to 0x00,0x04,0x08,0x0C, then read them back. Required: reads return 1,2,3,4; every BRESP and RRESP is 00; each AWREADY/ARREADY is a single-cycle pulse.
2. Write 0xAABBCCDD to 0x00, then write 0x11223344 with WSTRB=4'b0101. Required: read of 0x00 returns 0xAA22CC44.
3. Write CTRL=0x0003_0002, then DATA_IN = 10, 0xFFFFFFFD, 5. Required: ACC=12, STATUS=0x0003_0001, irq=1. A further DATA_IN of 100 leaves ACC=12 and COUNT=3.
4. CTRL=0x0002_0001, then DATA_IN = 0xFFFFFFFF, 2. Required: ACC=0x00000001, DONE=1. Then a DATA_IN with WSTRB=4'h7 is ignored.
5. After test 3, write CTRL=0x0003_0003. Required: ACC=0, STATUS=0, irq=0 by the second cycle; CTRL reads 0x0003_0002.
6. Hold BREADY and RREADY low for 10 cycles with AWVALID/WVALID reasserted. Required: BVALID and RVALID stay high, RDATA is stable, no second AWREADY. Then pull ARESETN low mid-transaction: all VALID/READY/irq outputs go 0 immediately, and all registers read 0 after release.
